nwr_target: RTL
===============

NWR_TARGET -- requirements
Module: nwr_target

Interface
REQ-001 SHALL have parameter CHECK_DEST_ID, default 1; when 1, packets whose tuser[15:0] differs from local_id are dropped.
REQ-002 log_clk  in  1  single clock for all logic.
REQ-003 log_rst_n  in  1  synchronous, active-low reset.
REQ-004 local_id  in  16  own SRIO device ID.
REQ-005 treq_tvalid/treq_tready/treq_tlast  in/out/in  1 each  inbound HELLO request stream.
REQ-006 treq_tdata  in  64  HELLO header beat, then payload; treq_tkeep in 8; treq_tuser in 32 = {src_id, dest_id}.
REQ-007 tresp_tvalid/tresp_tready/tresp_tlast  out/in/out  1 each  outbound response stream.
REQ-008 tresp_tdata  out  64; tresp_tkeep out 8; tresp_tuser out 32  response beat.
REQ-009 user_tvalid/user_tready  out/in  1  payload handshake.
REQ-010 user_tdata out 64; user_tkeep out 8; user_tfirst/user_tlast out 1  payload to user.
REQ-011 user_addr out 34; user_tsize out 16 (byte count); both held constant from first to last payload beat.
REQ-012 err_o  out  1  one-cycle pulse on length error; drop_cnt  out  16  count of dropped packets, saturating.

Function
REQ-013 Header decode: tid[63:56], ftype[55:52], ttype[51:48], prio[46:45], size[43:36] (bytes-1), addr[33:0].
REQ-014 States: IDLE, DATA, DROP, RESP; IDLE accepts header (treq_tready=1) and latches tid, prio, size, addr, src_id.
REQ-015 IDLE->DATA when ftype=5 and ttype in {4 NWRITE, 5 NWRITE_R} and ID check passes; otherwise IDLE->DROP, drop_cnt+1.
REQ-016 Header beat with treq_tlast=1 (no payload) -> err_o pulse, drop_cnt+1, stay IDLE.
REQ-017 DATA: treq_tready = user_tready; user_tvalid = treq_tvalid; zero-latency pass-through, no extra buffering.
REQ-018 user_tfirst=1 on first payload beat only; user_tsize = size+1 (1..256); expected beats = ceil((size+1)/8).
REQ-019 Beat counter 6 bits; user_tlast asserted on the treq_tlast beat.
REQ-020 treq_tlast beat count != expected -> err_o pulse on the tlast beat; the packet is still forwarded, no response generated.
REQ-021 DROP: treq_tready=1, consume until treq_tlast, then IDLE; user_tvalid stays 0.
REQ-022 DATA->RESP after tlast for NWRITE_R without error; else DATA->IDLE.
REQ-023 RESP: single beat, tresp_tlast=1, tresp_tkeep=FF, tdata = {tid, 4'hD, 4'h0, 1'b0, prio+1 (saturating at 3), 1'b0, 8'h00, 36'h0}, tuser = {local_id, src_id}.
REQ-024 tresp_tvalid held until tresp_tready; treq_tready=0 in RESP; RESP->IDLE on handshake.
REQ-025 Back-to-back packets: next header accepted the cycle after return to IDLE.

Reset
REQ-026 While log_rst_n=0 at posedge: state=IDLE, all valid/first/last/err outputs 0, treq_tready 0, drop_cnt 0, latched fields 0.
REQ-027 Reset mid-packet aborts immediately; remaining beats after reset are treated as a new header.

Configuration
REQ-028 NWR_TARGET_RESP_EN defined: NWRITE_R responses per REQ-022..024.
REQ-029 NWR_TARGET_RESP_EN undefined: RESP state absent, NWRITE_R handled as NWRITE, tresp_tvalid/tlast/tdata/tkeep/tuser tied 0.

Verification
REQ-030 NWRITE, size=8'h1F, addr=34'h3FF00FF00, 4 beats, user_tready=1 -> 4 user beats, tfirst beat 1, tlast beat 4, user_tsize=32, user_addr=3FF00FF00, no response.
REQ-031 NWRITE_R tid=8'h5A, prio=1, src=16'h01, local_id=16'hF0 -> after payload one tresp beat, tdata[63:48]=16'h5AD0, prio field 2, tuser=32'h00F00001.
REQ-032 user_tready toggling 0/1 every cycle on 8-beat packet -> treq_tready mirrors it, all 8 beats delivered in order, no loss.
REQ-033 ftype=6 packet of 3 beats, then valid NWRITE -> drop_cnt=1, no user output for first, second forwarded normally.
REQ-034 size=8'h0F but treq_tlast on beat 3 -> err_o pulse on that beat, no tresp.
REQ-035 log_rst_n=0 during beat 2 of 4 -> outputs zero next cycle, state IDLE, drop_cnt 0.

Source files
------------

// File: rtl/nwr_target.sv
// SRIO NWRITE / NWRITE_R target: decodes HELLO headers and streams payload to the user port.
// Define NWR_TARGET_RESP_EN to generate the single-beat response for NWRITE_R.
module nwr_target #(
    parameter int CHECK_DEST_ID = 1
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic [15:0] local_id,
    input  logic        treq_tvalid,
    output logic        treq_tready,
    input  logic        treq_tlast,
    input  logic [63:0] treq_tdata,
    input  logic [7:0]  treq_tkeep,
    input  logic [31:0] treq_tuser,
    output logic        tresp_tvalid,
    input  logic        tresp_tready,
    output logic        tresp_tlast,
    output logic [63:0] tresp_tdata,
    output logic [7:0]  tresp_tkeep,
    output logic [31:0] tresp_tuser,
    output logic        user_tvalid,
    input  logic        user_tready,
    output logic [63:0] user_tdata,
    output logic [7:0]  user_tkeep,
    output logic        user_tfirst,
    output logic        user_tlast,
    output logic [33:0] user_addr,
    output logic [15:0] user_tsize,
    output logic        err_o,
    output logic [15:0] drop_cnt
);

    localparam logic [3:0] FTYPE_WRITE    = 4'd5;
    localparam logic [3:0] TTYPE_NWRITE   = 4'd4;
    localparam logic [3:0] TTYPE_NWRITE_R = 4'd5;

`ifdef NWR_TARGET_RESP_EN
    typedef enum logic [1:0] {IDLE, DATA, DROP, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
`endif

    state_t      state, state_next;
    logic [7:0]  size_r;
    logic [33:0] addr_r;
    logic [5:0]  beat_cnt;
    logic [15:0] drop_r;
    logic        hdr_ok, data_hs, len_err, resp_active;
    logic [5:0]  exp_beats;
`ifdef NWR_TARGET_RESP_EN
    logic [7:0]  tid_r;
    logic [1:0]  prio_r;
    logic [15:0] src_r;
    logic        nwr_r_r;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [1:0] prio_inc(input logic [1:0] p);
        return (p == 2'd3) ? p : p + 2'd1;
    endfunction

    assign hdr_ok = (treq_tdata[55:52] == FTYPE_WRITE) &&
                    ((treq_tdata[51:48] == TTYPE_NWRITE) || (treq_tdata[51:48] == TTYPE_NWRITE_R)) &&
                    ((CHECK_DEST_ID == 0) || (treq_tuser[15:0] == local_id));
    assign data_hs   = treq_tvalid && user_tready;
    assign exp_beats = {1'b0, size_r[7:3]} + 6'd1;
    assign len_err   = treq_tlast && ((beat_cnt + 6'd1) != exp_beats);

    always_ff @(posedge log_clk) begin
        if (!log_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (treq_tvalid && !treq_tlast) state_next = hdr_ok ? DATA : DROP;
            DATA: if (data_hs && treq_tlast) begin
                state_next = IDLE;
`ifdef NWR_TARGET_RESP_EN
                if (nwr_r_r && !len_err) state_next = RESP;
`endif
            end
            DROP: if (treq_tvalid && treq_tlast) state_next = IDLE;
`ifdef NWR_TARGET_RESP_EN
            RESP: if (tresp_tready) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs are held quiet for as long as reset is asserted, not just after the first edge.
    always_comb begin
        treq_tready = 1'b0;
        user_tvalid = 1'b0;
        user_tfirst = 1'b0;
        user_tlast  = 1'b0;
        err_o       = 1'b0;
        resp_active = 1'b0;
        if (log_rst_n) begin
            case (state)
                IDLE: begin
                    treq_tready = 1'b1;
                    err_o       = treq_tvalid && treq_tlast;
                end
                DATA: begin
                    treq_tready = user_tready;
                    user_tvalid = treq_tvalid;
                    user_tfirst = treq_tvalid && (beat_cnt == 6'd0);
                    user_tlast  = treq_tvalid && treq_tlast;
                    err_o       = data_hs && len_err;
                end
                DROP: treq_tready = 1'b1;
`ifdef NWR_TARGET_RESP_EN
                RESP: resp_active = 1'b1;
`endif
                default: treq_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge log_clk) begin
        if (!log_rst_n) begin
            size_r   <= '0;
            addr_r   <= '0;
            beat_cnt <= '0;
            drop_r   <= '0;
`ifdef NWR_TARGET_RESP_EN
            tid_r    <= '0;
            prio_r   <= '0;
            src_r    <= '0;
            nwr_r_r  <= 1'b0;
`endif
        end else if (state == IDLE && treq_tvalid) begin
            size_r   <= treq_tdata[43:36];
            addr_r   <= treq_tdata[33:0];
            beat_cnt <= '0;
`ifdef NWR_TARGET_RESP_EN
            tid_r    <= treq_tdata[63:56];
            prio_r   <= treq_tdata[46:45];
            src_r    <= treq_tuser[31:16];
            nwr_r_r  <= (treq_tdata[51:48] == TTYPE_NWRITE_R);
`endif
            if (treq_tlast || !hdr_ok) drop_r <= sat_inc(drop_r);
        end else if (state == DATA && data_hs) begin
            beat_cnt <= beat_cnt + 6'd1;
        end
    end

    assign user_tdata = treq_tdata;
    assign user_tkeep = treq_tkeep;
    assign user_addr  = addr_r;
    assign user_tsize = {8'h00, size_r} + 16'd1;
    assign drop_cnt   = drop_r;

`ifdef NWR_TARGET_RESP_EN
    assign tresp_tvalid = resp_active;
    assign tresp_tlast  = resp_active;
    assign tresp_tkeep  = {8{resp_active}};
    assign tresp_tdata  = {tid_r, 4'hD, 4'h0, 1'b0, prio_inc(prio_r), 1'b0, 8'h00, 36'h0};
    assign tresp_tuser  = {local_id, src_r};
`else
    logic unused;
    assign unused       = &{1'b0, treq_tuser[31:16], tresp_tready, resp_active};
    assign tresp_tvalid = 1'b0;
    assign tresp_tlast  = 1'b0;
    assign tresp_tkeep  = '0;
    assign tresp_tdata  = '0;
    assign tresp_tuser  = '0;
`endif

endmodule
